bit_serializer: RTL and testbench
=================================

# bit_serializer

Parallel-to-serial front end for the 1001 sequence detector. Accepts W-bit words over a valid/ready handshake, buffers one word ahead, and shifts bits out one per clock on `x` with no gap between back-to-back words. Output `x` connects directly to the detector's `x` input. When no word is in flight, `x` holds a programmable idle level.

## Interface
Parameters:
- `W`, 8, word width in bits (≥2)
- `MSB_FIRST`, 1, 1 = shift MSB first; 0 = LSB first
- `IDLE_BIT`, 0, value driven on `x` when not shifting
- `CNT_W`, 16, width of the `words_sent` counter

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `din`  in  W  parallel word
- `din_valid`  in  1  `din` is valid
- `din_ready`  out  1  block can accept a word this cycle
- `x`  out  1  serial bit to detector
- `x_valid`  out  1  `x` carries a data bit (not idle fill)
- `word_done`  out  1  `x` carries the last bit of the current word
- `busy`  out  1  shifting, or holding a word
- `words_sent`  out  CNT_W  count of fully shifted words, wraps

## Operation
- Registers:
  - `state` ∈ {IDLE, SHIFT}
  - `sh[W-1:0]`, shift register
  - `cnt`, bit index, width $clog2(W)
  - `hold[W-1:0]` plus `hold_full`, one-word skid buffer
  - `words_sent`
- Handshake:
  - Transfer occurs on a rising edge where `din_valid && din_ready`.
  - `din_ready = !hold_full`, forced 0 while `rst_n` is low.
  - `din` is sampled only on a transfer.
- IDLE + transfer: `din` goes to `sh`, `cnt` = 0, state goes to SHIFT. `hold` is untouched.
- SHIFT, not last bit (`cnt != W-1`):
  - `sh` shifts by 1 toward the output end.
  - `cnt` increments.
  - A transfer loads `hold` and sets `hold_full`.
- SHIFT, last bit (`cnt == W-1`), exactly one branch applies:
  - `hold_full`: `hold` goes to `sh`, `cnt` = 0, `hold_full` clears, state stays SHIFT. Any transfer this edge goes to `hold`; `hold_full` remains 1.
  - `!hold_full` with a transfer: `din` bypasses to `sh`, `cnt` = 0, state stays SHIFT.
  - `!hold_full` without a transfer: state goes to IDLE.
  - In every case `words_sent` increments (modulo 2^CNT_W).
- Outputs are decoded from registers only; there is no combinational path from `din`/`din_valid` to any output.
  - `x = (state==SHIFT) ? (MSB_FIRST ? sh[W-1] : sh[0]) : IDLE_BIT`
  - `x_valid = (state==SHIFT)`
  - `word_done = (state==SHIFT) && (cnt==W-1)`
  - `busy = (state==SHIFT) || hold_full`
- No abort input. Once accepted, a word always shifts out completely unless reset asserts.

## Timing
- Reset (asynchronous, immediate): state IDLE, `sh`=0, `cnt`=0, `hold`=0, `hold_full`=0, `words_sent`=0. Resulting outputs: `x`=IDLE_BIT, `x_valid`=0, `word_done`=0, `busy`=0, `din_ready`=0 while low and 1 after deassertion.
- Latency: a word transferred at edge k drives its first bit on `x` during cycle k..k+1. Its last bit appears at k+W-1..k+W.
- Throughput: one bit per clock. Consecutive words are gapless if each next word transfers before or on the last-bit edge of the current one.
- Backpressure: with `hold_full`=1, `din_ready`=0 until the last-bit edge of the current word frees the skid buffer.
- Reset mid-word: the partial word and any held word are discarded. No `word_done` or counter increment for either.
- `words_sent` updates on the edge that ends the last-bit cycle. It is visible the cycle after `word_done`.

## Structure
- Shared package `ser_pkg`:
  - state enum `ser_state_t` {IDLE, SHIFT}
  - default constants `SER_W_DEF`=8, `SER_CNT_W_DEF`=16
- One sub-module: `ser_skid_reg`, the one-entry W-bit buffer with `load`/`unload`/`full`. Shift logic, counter and FSM live in `bit_serializer`.

## Test plan
- W=4, MSB_FIRST=1; reset, then one transfer of `din`=4'b1001 → `x` = 1,0,0,1 over 4 cycles. `x_valid` is high for those 4 cycles. `word_done` is high on the 4th. Detector `z` fires on the 4th. `words_sent`=1. `x` returns to 0.
- W=4; transfers of 4'h9 and 4'h6 back-to-back (`din_valid` held high) → 8 contiguous valid bits 1,0,0,1,0,1,1,0. `din_ready` drops after the second transfer and rises on the first word's last-bit edge. `words_sent`=2.
- W=4; three words offered continuously → the third transfer stalls until the first word's last-bit edge. No bit lost or duplicated, 12 valid bits total.
- W=4, MSB_FIRST=0; `din`=4'b0011 → `x` = 1,1,0,0.
- Reset asserted after 2 bits of a 4'hF word with 4'h9 held → `x`=IDLE_BIT immediately, `words_sent` stays 0, `busy`=0. After release, a new 4'h1 shifts as 0,0,0,1.
- CNT_W=2; 5 words → `words_sent` sequence 1,2,3,0,1.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared types and defaults for the bit serializer.
package ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam int SER_W_DEF     = 8;
  localparam int SER_CNT_W_DEF = 16;

endpackage

// File: rtl/bit_serializer_if.sv
// Parallel word handshake into the serializer.
interface bit_serializer_if
  import ser_pkg::*;
#(
  parameter int W = SER_W_DEF
);
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;

  modport master (output din, output din_valid, input  din_ready);
  modport slave  (input  din, input  din_valid, output din_ready);
endinterface

// File: rtl/ser_skid_reg.sv
// One-entry W-bit skid buffer. A load wins over an unload on the same edge,
// so the buffer can be drained into the shifter and refilled at once.
module ser_skid_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         unload,
  input  logic [W-1:0] din,
  output logic [W-1:0] q,
  output logic         full
);

  // Capture a word on load; flag clears only when drained without refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      full <= 1'b0;
    end else if (load) begin
      q    <= din;
      full <= 1'b1;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: one word shifting, one word held ahead,
// gapless output across back-to-back words.
module bit_serializer
  import ser_pkg::*;
#(
  parameter int W         = SER_W_DEF,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0,
  parameter int CNT_W     = SER_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  bit_serializer_if.slave  in_bus,
  output logic             x,
  output logic             x_valid,
  output logic             word_done,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  ser_state_t   state, state_nxt;
  logic [W-1:0] sh;
  logic [CW-1:0] cnt;
  logic [W-1:0] hold;
  logic         hold_full;
  logic         xfer, last, load, unload;

  // Ready depends on registers and reset only, never on din_valid.
  assign in_bus.din_ready = rst_n && !hold_full;
  assign xfer   = in_bus.din_valid && in_bus.din_ready;
  assign last   = (state == SHIFT) && (cnt == LAST);
  // A word goes to the buffer while shifting, unless the last-bit edge
  // with an empty buffer lets it bypass straight into the shifter.
  assign load   = xfer && (state == SHIFT) && (!last || hold_full);
  assign unload = last && hold_full;

  ser_skid_reg #(.W(W)) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .unload (unload),
    .din    (in_bus.din),
    .q      (hold),
    .full   (hold_full)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: start on a transfer, stop only when nothing follows.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (xfer) state_nxt = SHIFT;
      SHIFT: if (last && !hold_full && !xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register, bit index and completed-word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh         <= '0;
      cnt        <= '0;
      words_sent <= '0;
    end else if (state == IDLE) begin
      if (xfer) begin
        sh  <= in_bus.din;
        cnt <= '0;
      end
    end else if (!last) begin
      sh  <= MSB_FIRST ? {sh[W-2:0], 1'b0} : {1'b0, sh[W-1:1]};
      cnt <= cnt + CW'(1);
    end else begin
      words_sent <= words_sent + CNT_W'(1);
      if (hold_full) begin
        sh  <= hold;
        cnt <= '0;
      end else if (xfer) begin
        sh  <= in_bus.din;
        cnt <= '0;
      end
    end
  end

  // Outputs decoded from registers only.
  always_comb begin
    x         = (state == SHIFT) ? (MSB_FIRST ? sh[W-1] : sh[0]) : IDLE_BIT;
    x_valid   = (state == SHIFT);
    word_done = last;
    busy      = (state == SHIFT) || hold_full;
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Two serializers (MSB-first/idle 0/2-bit counter, LSB-first/idle 1/16-bit
// counter) driven by the same word stream and checked against a queue model.
module tb_bit_serializer;
  import ser_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [W-1:0] din_r;
  logic         vld_r;

  bit_serializer_if #(.W(W)) bus_m ();
  bit_serializer_if #(.W(W)) bus_l ();
  assign bus_m.din       = din_r;
  assign bus_m.din_valid = vld_r;
  assign bus_l.din       = din_r;
  assign bus_l.din_valid = vld_r;

  logic        xm, xvm, wdm, bm;
  logic [1:0]  wsm;
  logic        xl, xvl, wdl, bl;
  logic [15:0] wsl;

  bit_serializer #(.W(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .CNT_W(2)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_bus(bus_m), .x(xm), .x_valid(xvm),
    .word_done(wdm), .busy(bm), .words_sent(wsm)
  );

  bit_serializer #(.W(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1), .CNT_W(16)) dut_l (
    .clk(clk), .rst_n(rst_n), .in_bus(bus_l), .x(xl), .x_valid(xvl),
    .word_done(wdl), .busy(bl), .words_sent(wsl)
  );

  // Model: words in flight (front one is on the wire), bit position, total sent.
  logic [W-1:0] mq[$];
  int pos;
  int sent;
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    pos  = 0;
    sent = 0;
  endtask

  // One clock edge: advance the word on the wire, then accept any transfer.
  task automatic model_edge();
    bit xf;
    if (!rst_n) begin
      model_reset();
    end else begin
      xf = vld_r && (mq.size() < 2);
      if (mq.size() > 0) begin
        if (pos == W - 1) begin
          void'(mq.pop_front());
          sent++;
          pos = 0;
        end else begin
          pos++;
        end
      end
      if (xf) mq.push_back(din_r);
    end
  endtask

  task automatic check_all();
    logic [W-1:0] w;
    bit act, dn, rdy;
    act = (mq.size() > 0);
    w   = act ? mq[0] : '0;
    dn  = act && (pos == W - 1);
    rdy = rst_n && (mq.size() < 2);
    chk("x_msb",       32'(xm),  act ? 32'(w[W-1-pos]) : 32'd0);
    chk("x_lsb",       32'(xl),  act ? 32'(w[pos])     : 32'd1);
    chk("x_valid_m",   32'(xvm), 32'(act));
    chk("x_valid_l",   32'(xvl), 32'(act));
    chk("word_done_m", 32'(wdm), 32'(dn));
    chk("word_done_l", 32'(wdl), 32'(dn));
    chk("busy_m",      32'(bm),  32'(act));
    chk("busy_l",      32'(bl),  32'(act));
    chk("ready_m",     32'(bus_m.din_ready), 32'(rdy));
    chk("ready_l",     32'(bus_l.din_ready), 32'(rdy));
    chk("words_m",     32'(wsm), 32'(sent % 4));
    chk("words_l",     32'(wsl), 32'(sent % 65536));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  // Offer words continuously until n have been accepted (bounded).
  task automatic send_words(input int n, input logic [W-1:0] w0, input logic [W-1:0] w1,
                            input logic [W-1:0] w2);
    int acc = 0;
    int cyc = 0;
    bit will;
    vld_r = 1'b1;
    while (acc < n && cyc < 50) begin
      din_r = (acc == 0) ? w0 : (acc == 1) ? w1 : (acc == 2) ? w2 : W'($urandom);
      will  = (mq.size() < 2);
      tick();
      if (will) acc++;
      cyc++;
    end
    vld_r = 1'b0;
    chk("send_accepted", 32'(acc), 32'(n));
  endtask

  initial begin
    rst_n = 1'b0;
    din_r = '0;
    vld_r = 1'b0;
    model_reset();
    #1 check_all();
    repeat (2) tick();
    rst_n = 1'b1;
    #1 check_all();

    // Single 1001 word, MSB first on dut_m, LSB first on dut_l.
    din_r = 4'b1001; vld_r = 1'b1;
    tick();
    vld_r = 1'b0;
    repeat (5) tick();
    chk("one_word_sent", 32'(wsl), 32'd1);

    // Back-to-back 9 then 6; second lands in the skid buffer.
    send_words(2, 4'h9, 4'h6, 4'h0);
    chk("ready_low_held", 32'(bus_m.din_ready), 32'd0);
    repeat (9) tick();
    chk("two_more_sent", 32'(wsl), 32'd3);

    // Three words offered continuously; the third stalls.
    send_words(3, 4'hA, 4'h5, 4'hC);
    repeat (14) tick();
    chk("three_more_sent", 32'(wsl), 32'd6);

    // LSB-first 0011 on dut_l (model covers x = 1,1,0,0).
    din_r = 4'b0011; vld_r = 1'b1;
    tick();
    vld_r = 1'b0;
    repeat (5) tick();

    // Reset mid-word with a word held: everything discarded.
    rst_n = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;
    #1;
    send_words(2, 4'hF, 4'h9, 4'h0);
    chk("mid_busy_before", 32'(bm), 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1 check_all();
    chk("rst_x_idle_l", 32'(xl), 32'd1);
    tick();
    rst_n = 1'b1;
    din_r = 4'h1; vld_r = 1'b1;
    tick();
    vld_r = 1'b0;
    repeat (5) tick();
    chk("after_rst_sent", 32'(wsl), 32'd1);

    // Four more words: 2-bit counter wraps 1 -> 2,3,0,1.
    send_words(4, 4'h3, 4'h8, 4'hE);
    repeat (10) tick();
    chk("wrap_count_m", 32'(wsm), 32'd1);
    chk("wrap_count_l", 32'(wsl), 32'd5);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      vld_r = (($urandom % 10) < 7);
      din_r = W'($urandom);
      tick();
    end
    vld_r = 1'b0;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
